// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
//   Pipelined bitwise logic unit. Each accepted transaction selects one of
//   eight bitwise functions of in_a/in_b. The result and its zero and parity
//   flags travel together through a LATENCY-deep valid/ready pipeline that
//   supports full backpressure. A free-running counter tracks completed
//   output handshakes.
//
// Parameters
//   WIDTH    operand/result width (>=1)
//   LATENCY  pipeline depth from input accept to output valid (1..4)
//   CNT_W    width of the transaction counter (wraps silently)
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input handshake; in_a, in_b, in_op sampled on it
//   out_valid/out_ready    output handshake
//   out_data               result
//   out_zero/out_parity    result == 0 / XOR-reduction of result
//   txn_count              number of completed output handshakes
// ---------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] txn_count
);

  // Payload layout: {parity, zero, data}
  localparam int PW = WIDTH + 2;

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("logic_unit_pipe: LATENCY must be in 1..4");
    end
  endgenerate

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~(a & b);
      3'd3:    r = ~(a | b);
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [PW-1:0] pack_result(input logic [WIDTH-1:0] r);
    return {^r, (r == '0), r};
  endfunction

  logic [LATENCY-1:0] vld_p;
  logic [LATENCY-1:0] adv_p;
  logic [PW-1:0]      pay_p [LATENCY];
  logic [PW-1:0]      pay_in;
  logic               accept;
  logic               emit;

  // A stage may move forward when any stage downstream of it holds a bubble,
  // or when the consumer takes the head. Scanning from the output end keeps
  // this a simple prefix without a combinational chain on adv_p itself.
  always_comb begin : advance_calc
    logic space;
    adv_p = '0;
    space = out_ready;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      adv_p[k] = vld_p[k] && space;
      space    = space || !vld_p[k];
    end
  end

  assign in_ready = !vld_p[0] || adv_p[0];
  assign accept   = in_valid && in_ready;
  assign emit     = vld_p[LATENCY-1] && out_ready;
  assign pay_in   = pack_result(logic_op(in_op, in_a, in_b));

  // Stage 0: capture the computed result and flags on an input handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p[0] <= 1'b0;
    end else if (accept) begin
      vld_p[0] <= 1'b1;
    end else if (adv_p[0]) begin
      vld_p[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pay_p[0] <= pay_in;
    end
  end

  // Stages 1..LATENCY-1: shift forward when the upstream stage advances
  generate
    for (genvar k = 1; k < LATENCY; k++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p[k] <= 1'b0;
        end else if (adv_p[k-1]) begin
          vld_p[k] <= 1'b1;
        end else if (adv_p[k]) begin
          vld_p[k] <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (adv_p[k-1]) begin
          pay_p[k] <= pay_p[k-1];
        end
      end
    end
  endgenerate

  // Output: payload registers are not reset, so the head is gated with its
  // valid bit to present zeros while the pipeline is empty.
  logic [PW-1:0] head;
  assign head       = vld_p[LATENCY-1] ? pay_p[LATENCY-1] : '0;
  assign out_valid  = vld_p[LATENCY-1];
  assign out_data   = head[WIDTH-1:0];
  assign out_zero   = head[WIDTH];
  assign out_parity = head[WIDTH+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count <= '0;
    end else if (emit) begin
      txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule
